// File: rtl/sp3_align_ctrl.sv
// sp3_align_ctrl: frame-alignment controller for the SPROCKET3 lpGBT uplink
// streams A and B. Each channel watches its decoder's header-check results,
// requests single bitslips from the demux until the header is found, declares
// lock and tracks loss of lock. A shared round-robin scheduler serialises slips.
//
// Ports:
//   mgtclk_div2                 controller clock (demux output clock)
//   reset_n                     asynchronous active-low reset
//   enable                      alignment enable (level)
//   frame_valid_a/b, hdr_ok_a/b per-channel header-check strobe and result
//   bitslip_a/b                 single-cycle slip pulse to the demux
//   locked_a/b                  channel aligned
//   align_fail_a/b              channel exhausted MAX_SLIPS
//   slip_count_a/b [5:0]        slips issued in the current search
//   unlock_events_a/b [15:0]    lock-loss counters, present only when the
//                               macro SP3_ALIGN_STATS_EN is defined
module sp3_align_ctrl #(
   parameter int unsigned LOCK_CNT     = 16,
   parameter int unsigned UNLOCK_CNT   = 4,
   parameter int unsigned SLIP_HOLDOFF = 16,
   parameter int unsigned MAX_SLIPS    = 32
) (
   input  logic       mgtclk_div2,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       frame_valid_a,
   input  logic       hdr_ok_a,
   input  logic       frame_valid_b,
   input  logic       hdr_ok_b,
   output logic       bitslip_a,
   output logic       bitslip_b,
   output logic       locked_a,
   output logic       locked_b,
   output logic       align_fail_a,
   output logic       align_fail_b,
   output logic [5:0] slip_count_a,
   output logic [5:0] slip_count_b
`ifdef SP3_ALIGN_STATS_EN
   ,
   output logic [15:0] unlock_events_a,
   output logic [15:0] unlock_events_b
`endif
);

   localparam int unsigned GW = $clog2(LOCK_CNT + 1);
   localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
   localparam int unsigned HW = $clog2(SLIP_HOLDOFF + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_REQ, S_SLIP, S_HOLD, S_LOCKED, S_FAIL
   } state_t;

   logic [1:0] w_fv;
   logic [1:0] w_ok;
   logic [1:0] w_req;
   logic [1:0] w_gnt;
   logic       r_ptr;   // 0 = channel A has priority, 1 = channel B

   assign w_fv = {frame_valid_b, frame_valid_a};
   assign w_ok = {hdr_ok_b, hdr_ok_a};

   // A lone requester is granted at once; on contention the pointer channel wins.
   assign w_gnt[0] = w_req[0] & (~w_req[1] | ~r_ptr);
   assign w_gnt[1] = w_req[1] & (~w_req[0] |  r_ptr);

   // Pointer moves only on a contended grant, so a lone request does not
   // steal priority from the channel that lost the last contest.
   always_ff @(posedge mgtclk_div2 or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= 1'b0;
      end else if (w_req[0] && w_req[1]) begin
         r_ptr <= ~r_ptr;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      state_t        r_state;
      logic [GW-1:0] r_good;
      logic [BW-1:0] r_bad;
      logic [HW-1:0] r_hold;
      logic [5:0]    r_slips;
      logic          r_bitslip;
      logic          r_locked;
      logic          r_fail;
      logic          w_unlock_ev;

      // Requests are withdrawn the moment enable drops.
      assign w_req[g]    = enable && (r_state == S_REQ);
      assign w_unlock_ev = enable && (r_state == S_LOCKED) && w_fv[g] && !w_ok[g]
                           && (r_bad == BW'(UNLOCK_CNT - 1));

      // Per-channel alignment FSM with registered outputs.
      always_ff @(posedge mgtclk_div2 or negedge reset_n) begin
         if (!reset_n) begin
            r_state   <= S_IDLE;
            r_good    <= '0;
            r_bad     <= '0;
            r_hold    <= '0;
            r_slips   <= '0;
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
         end else begin
            r_bitslip <= 1'b0;
            if (!enable) begin
               r_state  <= S_IDLE;
               r_good   <= '0;
               r_bad    <= '0;
               r_hold   <= '0;
               r_slips  <= '0;
               r_locked <= 1'b0;
               r_fail   <= 1'b0;
            end else begin
               case (r_state)
                  S_IDLE: begin
                     r_state <= S_CHECK;
                     r_good  <= '0;
                     r_bad   <= '0;
                     r_slips <= '0;
                  end
                  S_CHECK: begin
                     if (w_fv[g]) begin
                        if (w_ok[g]) begin
                           r_good <= r_good + GW'(1);
                           if (r_good == GW'(LOCK_CNT - 1)) begin
                              r_state  <= S_LOCKED;
                              r_locked <= 1'b1;
                              r_bad    <= '0;
                           end
                        end else begin
                           r_good <= '0;
                           if (r_slips == 6'(MAX_SLIPS)) begin
                              r_state <= S_FAIL;
                              r_fail  <= 1'b1;
                           end else begin
                              r_state <= S_REQ;
                           end
                        end
                     end
                  end
                  S_REQ: begin
                     // bitslip rises together with entry to SLIP
                     if (w_gnt[g]) begin
                        r_state   <= S_SLIP;
                        r_bitslip <= 1'b1;
                        if (r_slips != 6'd63) begin
                           r_slips <= r_slips + 6'd1;
                        end
                     end
                  end
                  S_SLIP: begin
                     r_state <= S_HOLD;
                     r_hold  <= HW'(SLIP_HOLDOFF);
                  end
                  S_HOLD: begin
                     if (r_hold == '0) begin
                        r_state <= S_CHECK;
                        r_good  <= '0;
                     end else begin
                        r_hold <= r_hold - HW'(1);
                     end
                  end
                  S_LOCKED: begin
                     if (w_unlock_ev) begin
                        r_state  <= S_CHECK;
                        r_locked <= 1'b0;
                        r_slips  <= '0;
                        r_good   <= '0;
                        r_bad    <= '0;
                     end else if (w_fv[g]) begin
                        r_bad <= w_ok[g] ? '0 : r_bad + BW'(1);
                     end
                  end
                  S_FAIL: begin
                     r_state <= S_FAIL;
                  end
                  default: begin
                     r_state <= S_IDLE;
                  end
               endcase
            end
         end
      end

`ifdef SP3_ALIGN_STATS_EN
      logic [15:0] r_unlock;

      // Saturating lock-loss counter, survives enable toggles.
      always_ff @(posedge mgtclk_div2 or negedge reset_n) begin
         if (!reset_n) begin
            r_unlock <= '0;
         end else if (w_unlock_ev && (r_unlock != 16'hFFFF)) begin
            r_unlock <= r_unlock + 16'd1;
         end
      end
`endif
   end

   assign bitslip_a    = g_ch[0].r_bitslip;
   assign bitslip_b    = g_ch[1].r_bitslip;
   assign locked_a     = g_ch[0].r_locked;
   assign locked_b     = g_ch[1].r_locked;
   assign align_fail_a = g_ch[0].r_fail;
   assign align_fail_b = g_ch[1].r_fail;
   assign slip_count_a = g_ch[0].r_slips;
   assign slip_count_b = g_ch[1].r_slips;
`ifdef SP3_ALIGN_STATS_EN
   assign unlock_events_a = g_ch[0].r_unlock;
   assign unlock_events_b = g_ch[1].r_unlock;
`endif

endmodule

// File: tb/tb_sp3_align_ctrl.sv
// Self-checking bench for sp3_align_ctrl: directed scenarios with
// hand-computed expectations.
module tb_sp3_align_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       fv_a = 1'b0, ok_a = 1'b0, fv_b = 1'b0, ok_b = 1'b0;
   logic       bitslip_a, bitslip_b, locked_a, locked_b, align_fail_a, align_fail_b;
   logic [5:0] slip_count_a, slip_count_b;
`ifdef SP3_ALIGN_STATS_EN
   logic [15:0] unlock_events_a, unlock_events_b;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sp3_align_ctrl dut (
      .mgtclk_div2   (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .frame_valid_a (fv_a),
      .hdr_ok_a      (ok_a),
      .frame_valid_b (fv_b),
      .hdr_ok_b      (ok_b),
      .bitslip_a     (bitslip_a),
      .bitslip_b     (bitslip_b),
      .locked_a      (locked_a),
      .locked_b      (locked_b),
      .align_fail_a  (align_fail_a),
      .align_fail_b  (align_fail_b),
      .slip_count_a  (slip_count_a),
      .slip_count_b  (slip_count_b)
`ifdef SP3_ALIGN_STATS_EN
      ,
      .unlock_events_a (unlock_events_a),
      .unlock_events_b (unlock_events_b)
`endif
   );

   // Pulse monitor: counts pulses, over-wide pulses, overlap and short gaps.
   int   n_cyc = 0, slips_a = 0, slips_b = 0, both_hi = 0, wide = 0, gap_a = 0;
   int   last_a = -1000;
   logic prev_a = 1'b0, prev_b = 1'b0;
   always @(negedge clk) begin
      n_cyc++;
      if (bitslip_a) slips_a++;
      if (bitslip_b) slips_b++;
      if (bitslip_a && bitslip_b) both_hi++;
      if ((bitslip_a && prev_a) || (bitslip_b && prev_b)) wide++;
      if (bitslip_a && !prev_a) begin
         if (n_cyc - last_a < 16) gap_a++;
         last_a = n_cyc;
      end
      prev_a = bitslip_a;
      prev_b = bitslip_b;
   end

   // Advance one clock; outputs then reflect the edge just taken.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle header-check strobe on either/both channels.
   task automatic strobe(input logic fa, input logic oa, input logic fb, input logic ob);
      fv_a = fa; ok_a = oa; fv_b = fb; ok_b = ob;
      tick();
      fv_a = 1'b0; ok_a = 1'b0; fv_b = 1'b0; ok_b = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      fv_a = 1'b0; ok_a = 1'b0; fv_b = 1'b0; ok_b = 1'b0;
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic start();
      do_reset();
      enable = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bitslip_a, bitslip_b, locked_a, locked_b, align_fail_a, align_fail_b} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {bitslip_a, bitslip_b, locked_a, locked_b, align_fail_a, align_fail_b});
      end
      checks++;
      if ({slip_count_a, slip_count_b} !== 12'd0) begin
         failures++;
         $display("FAIL reset_counts: got %0d/%0d expected 0/0", slip_count_a, slip_count_b);
      end
   endtask

   task automatic test_lock();
      int s0;
      start();
      s0 = slips_a;
      repeat (15) strobe(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b0) begin
         failures++;
         $display("FAIL lock_early: got %b expected 0", locked_a);
      end
      strobe(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b1) begin
         failures++;
         $display("FAIL lock_16: got %b expected 1", locked_a);
      end
      checks++;
      if (slips_a - s0 !== 0 || slip_count_a !== 6'd0) begin
         failures++;
         $display("FAIL lock_noslip: got pulses=%0d count=%0d expected 0/0", slips_a - s0, slip_count_a);
      end
   endtask

   task automatic test_slip();
      int s0, g0, w0;
      start();
      s0 = slips_a; g0 = gap_a; w0 = wide;
      for (int i = 0; i < 3; i++) begin
         strobe(1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         checks++;
         if (bitslip_a !== 1'b1) begin
            failures++;
            $display("FAIL slip_latency_%0d: got %b expected 1", i, bitslip_a);
         end
         repeat (4) tick();
         strobe(1'b1, 1'b0, 1'b0, 1'b0);   // lands in holdoff
         repeat (20) tick();
         strobe(1'b1, 1'b1, 1'b0, 1'b0);
      end
      repeat (16) strobe(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (slips_a - s0 !== 3) begin
         failures++;
         $display("FAIL slip_pulses: got %0d expected 3", slips_a - s0);
      end
      checks++;
      if (slip_count_a !== 6'd3) begin
         failures++;
         $display("FAIL slip_count: got %0d expected 3", slip_count_a);
      end
      checks++;
      if (locked_a !== 1'b1) begin
         failures++;
         $display("FAIL slip_locked: got %b expected 1", locked_a);
      end
      checks++;
      if (wide - w0 !== 0 || gap_a - g0 !== 0) begin
         failures++;
         $display("FAIL slip_shape: got wide=%0d gaps=%0d expected 0/0", wide - w0, gap_a - g0);
      end
   endtask

   task automatic test_arbitration();
      start();
      for (int p = 0; p < 2; p++) begin
         strobe(1'b1, 1'b0, 1'b1, 1'b0);
         checks++;
         if ({bitslip_a, bitslip_b} !== 2'b00) begin
            failures++;
            $display("FAIL arb%0d_c1: got %b expected 00", p, {bitslip_a, bitslip_b});
         end
         tick();
         checks++;
         if ({bitslip_a, bitslip_b} !== ((p == 0) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL arb%0d_c2: got %b expected %b", p, {bitslip_a, bitslip_b},
                     (p == 0) ? 2'b10 : 2'b01);
         end
         tick();
         checks++;
         if ({bitslip_a, bitslip_b} !== ((p == 0) ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL arb%0d_c3: got %b expected %b", p, {bitslip_a, bitslip_b},
                     (p == 0) ? 2'b01 : 2'b10);
         end
         repeat (25) tick();
      end
      checks++;
      if (slip_count_a !== 6'd2 || slip_count_b !== 6'd2) begin
         failures++;
         $display("FAIL arb_counts: got %0d/%0d expected 2/2", slip_count_a, slip_count_b);
      end
   endtask

   task automatic test_max_slips();
      int s0;
      start();
      s0 = slips_b;
      for (int i = 0; i < 34; i++) begin
         strobe(1'b0, 1'b0, 1'b1, 1'b0);
         repeat (22) tick();
      end
      checks++;
      if (slips_b - s0 !== 32) begin
         failures++;
         $display("FAIL max_pulses: got %0d expected 32", slips_b - s0);
      end
      checks++;
      if (align_fail_b !== 1'b1 || slip_count_b !== 6'd32) begin
         failures++;
         $display("FAIL max_fail: got fail=%b count=%0d expected 1/32", align_fail_b, slip_count_b);
      end
      checks++;
      if (align_fail_a !== 1'b0) begin
         failures++;
         $display("FAIL max_other: got %b expected 0", align_fail_a);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (align_fail_b !== 1'b0 || slip_count_b !== 6'd0) begin
         failures++;
         $display("FAIL max_disable: got fail=%b count=%0d expected 0/0", align_fail_b, slip_count_b);
      end
   endtask

   task automatic test_unlock();
      start();
      strobe(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (22) tick();
      repeat (16) strobe(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b1 || slip_count_a !== 6'd1) begin
         failures++;
         $display("FAIL unlock_pre: got locked=%b count=%0d expected 1/1", locked_a, slip_count_a);
      end
      repeat (3) strobe(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b1) begin
         failures++;
         $display("FAIL unlock_3bad: got %b expected 1", locked_a);
      end
      strobe(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) strobe(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b1) begin
         failures++;
         $display("FAIL unlock_good_clears: got %b expected 1", locked_a);
      end
      strobe(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (locked_a !== 1'b0 || slip_count_a !== 6'd0) begin
         failures++;
         $display("FAIL unlock_4bad: got locked=%b count=%0d expected 0/0", locked_a, slip_count_a);
      end
      strobe(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bitslip_a !== 1'b1) begin
         failures++;
         $display("FAIL unlock_reslip: got %b expected 1", bitslip_a);
      end
   endtask

   task automatic test_enable_drop();
      int s0;
      start();
      s0 = slips_a;
      strobe(1'b1, 1'b0, 1'b0, 1'b0);   // A now requesting
      enable = 1'b0;
      repeat (3) tick();
      checks++;
      if (slips_a - s0 !== 0 || bitslip_a !== 1'b0) begin
         failures++;
         $display("FAIL drop_req: got pulses=%0d expected 0", slips_a - s0);
      end
      // strobe in the same cycle as enable rising is ignored
      enable = 1'b1;
      strobe(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      checks++;
      if (slips_a - s0 !== 0) begin
         failures++;
         $display("FAIL enable_edge_strobe: got pulses=%0d expected 0", slips_a - s0);
      end
   endtask

   task automatic test_async_reset();
      start();
      strobe(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bitslip_a !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre: got %b expected 1", bitslip_a);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bitslip_a !== 1'b0 || slip_count_a !== 6'd0) begin
         failures++;
         $display("FAIL areset_drop: got slip=%b count=%0d expected 0/0", bitslip_a, slip_count_a);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

`ifdef SP3_ALIGN_STATS_EN
   task automatic test_stats();
      start();
      for (int k = 0; k < 2; k++) begin
         repeat (16) strobe(1'b1, 1'b1, 1'b0, 1'b0);
         repeat (4) strobe(1'b1, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (unlock_events_a !== 16'd2 || unlock_events_b !== 16'd0) begin
         failures++;
         $display("FAIL stats_count: got %0d/%0d expected 2/0", unlock_events_a, unlock_events_b);
      end
      enable = 1'b0;
      repeat (2) tick();
      enable = 1'b1;
      tick();
      checks++;
      if (unlock_events_a !== 16'd2) begin
         failures++;
         $display("FAIL stats_enable: got %0d expected 2", unlock_events_a);
      end
      do_reset();
      checks++;
      if (unlock_events_a !== 16'd0) begin
         failures++;
         $display("FAIL stats_reset: got %0d expected 0", unlock_events_a);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_lock();
      test_slip();
      test_arbitration();
      test_max_slips();
      test_unlock();
      test_enable_drop();
      test_async_reset();
`ifdef SP3_ALIGN_STATS_EN
      test_stats();
`endif
      checks++;
      if (both_hi !== 0 || wide !== 0) begin
         failures++;
         $display("FAIL pulse_rules: got overlap=%0d wide=%0d expected 0/0", both_hi, wide);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
